// File: rtl/settle_pkg.sv
// Shared types and helpers for the settling monitor.
//   state_e  : run-control FSM states
//   abs_diff : magnitude of the difference of two signed values. Operands are
//              carried at DIFF_W bits, so any sample width up to MAX_W bits
//              sign-extends into it without overflow.
package settle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EVAL,
    DONE
  } state_e;

  localparam int MAX_W  = 32;
  localparam int DIFF_W = MAX_W + 1;

  // |a - b| as an unsigned value. For WIDTH-bit inputs the result always fits
  // in WIDTH+1 bits; the upper bits are zero.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] a,
                                                 input logic signed [DIFF_W-1:0] b);
    logic signed [DIFF_W-1:0] d;
    d = a - b;
    return (d < 0) ? DIFF_W'(-d) : DIFF_W'(d);
  endfunction

endpackage

// File: rtl/win_accum.sv
// One channel of the settling monitor: signed window accumulator, window
// average and target-band compare.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the accumulator (wins over add)
//   add        : add the current sample into the accumulator
//   sample     : signed input sample
//   target     : signed band centre
//   tol        : unsigned band half-width
//   avg        : accumulator >>> LOG_WIN (floor), truncated to WIDTH
//   in_band    : |avg - target| <= tol
module win_accum
  import settle_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LOG_WIN = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    add,
  input  logic signed [WIDTH-1:0] sample,
  input  logic signed [WIDTH-1:0] target,
  input  logic        [WIDTH-1:0] tol,
  output logic signed [WIDTH-1:0] avg,
  output logic                    in_band
);

  // A full window of 2^LOG_WIN samples fits exactly in WIDTH+LOG_WIN bits.
  localparam int ACC_W = WIDTH + LOG_WIN;

  logic signed [ACC_W-1:0] acc_q, acc_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = acc_q + ACC_W'(sample);
    end
  end

  // NOTE: the accumulator is a single register, so it is reset like any other
  // flop; only real RAM arrays are left without reset.
  // NOTE: sequential state uses non-blocking assignment so all flops sample
  // their inputs from the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Arithmetic shift rounds toward minus infinity (e.g. -9/4 -> -3).
  assign avg     = WIDTH'(acc_q >>> LOG_WIN);
  assign in_band = abs_diff(DIFF_W'(avg), DIFF_W'(target)) <= DIFF_W'(tol);

endmodule

// File: rtl/settle_monitor.sv
// Multi-channel settling monitor. Each channel is averaged over windows of
// 2^LOG_WIN accepted samples and compared with a shared target band. After
// SETTLE_WINS consecutive windows with every channel in band the run ends
// settled; if the cycle budget runs out first it ends timed out.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : pulse; latch target/tol/timeout and (re)start a run
//   sample_en  : accept sig this cycle (only while accumulating)
//   sig        : NUM_CH packed signed samples, channel i at [i*WIDTH +: WIDTH]
//   target/tol : band centre (signed) and half-width (unsigned)
//   timeout    : cycle budget from start, 0 disables it
//   avg_out    : last window averages, avg_vld pulses when they update
//   in_band    : per-channel band result of the last window
//   busy       : run in progress; done pulses once when a run ends
//   settled / timed_out : how the last run ended, held until next start
module settle_monitor
  import settle_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 16,
  parameter int LOG_WIN     = 10,
  parameter int SETTLE_WINS = 4,
  parameter int TIMEOUT_W   = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sample_en,
  input  logic [NUM_CH*WIDTH-1:0] sig,
  input  logic signed [WIDTH-1:0] target,
  input  logic [WIDTH-1:0]        tol,
  input  logic [TIMEOUT_W-1:0]    timeout,
  output logic [NUM_CH*WIDTH-1:0] avg_out,
  output logic                    avg_vld,
  output logic [NUM_CH-1:0]       in_band,
  output logic                    busy,
  output logic                    done,
  output logic                    settled,
  output logic                    timed_out
);

  localparam int RUN_W = $clog2(SETTLE_WINS + 1);

  state_e                   state_q, state_d;
  logic [LOG_WIN-1:0]       cnt_q, cnt_d;
  logic [RUN_W-1:0]         run_q, run_d, run_next;
  logic [TIMEOUT_W-1:0]     cyc_q, cyc_d, cyc_inc;
  logic [TIMEOUT_W-1:0]     timeout_q, timeout_d;
  logic signed [WIDTH-1:0]  target_q, target_d;
  logic [WIDTH-1:0]         tol_q, tol_d;
  logic [NUM_CH*WIDTH-1:0]  avg_q, avg_d;
  logic                     avg_vld_q, avg_vld_d;
  logic [NUM_CH-1:0]        in_band_q, in_band_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     settled_q, settled_d;
  logic                     timed_out_q, timed_out_d;

  logic                     acc_clr, acc_add, timeout_hit;
  logic [NUM_CH*WIDTH-1:0]  win_avg;
  logic [NUM_CH-1:0]        win_in_band;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    win_accum #(
      .WIDTH   (WIDTH),
      .LOG_WIN (LOG_WIN)
    ) u_win (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (acc_clr),
      .add     (acc_add),
      .sample  (sig[i*WIDTH +: WIDTH]),
      .target  (target_q),
      .tol     (tol_q),
      .avg     (win_avg[i*WIDTH +: WIDTH]),
      .in_band (win_in_band[i])
    );
  end

  // The counter holds the number of edges since start; the budget expires on
  // the edge at which it would reach the timeout value.
  assign cyc_inc     = cyc_q + TIMEOUT_W'(1);
  assign timeout_hit = (timeout_q != '0) && (cyc_inc == timeout_q);
  assign run_next    = (&win_in_band) ? run_q + RUN_W'(1) : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    cyc_d       = cyc_q;
    timeout_d   = timeout_q;
    target_d    = target_q;
    tol_d       = tol_q;
    avg_d       = avg_q;
    avg_vld_d   = 1'b0;
    in_band_d   = in_band_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    settled_d   = settled_q;
    timed_out_d = timed_out_q;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;

    unique case (state_q)
      IDLE: ;
      ACCUM: begin
        cyc_d = cyc_inc;
        if (sample_en) begin
          acc_add = 1'b1;
          cnt_d   = cnt_q + LOG_WIN'(1);
          if (&cnt_q) state_d = EVAL;
        end
        if (timeout_hit) begin
          state_d     = DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      EVAL: begin
        cyc_d     = cyc_inc;
        avg_d     = win_avg;
        in_band_d = win_in_band;
        avg_vld_d = 1'b1;
        run_d     = run_next;
        // Settling is checked first so it wins a tie with the timeout.
        if (run_next == RUN_W'(SETTLE_WINS)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          settled_d = 1'b1;
        end else if (timeout_hit) begin
          state_d     = DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end else begin
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // start from any state behaves like a fresh start from IDLE and overrides
    // whatever the current state decided, including a pending done.
    if (start) begin
      state_d     = ACCUM;
      cnt_d       = '0;
      run_d       = '0;
      cyc_d       = '0;
      timeout_d   = timeout;
      target_d    = target;
      tol_d       = tol;
      avg_d       = avg_q;
      avg_vld_d   = 1'b0;
      in_band_d   = in_band_q;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      settled_d   = 1'b0;
      timed_out_d = 1'b0;
      acc_clr     = 1'b1;
      acc_add     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_q       <= '0;
      cyc_q       <= '0;
      timeout_q   <= '0;
      target_q    <= '0;
      tol_q       <= '0;
      avg_q       <= '0;
      avg_vld_q   <= 1'b0;
      in_band_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      settled_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      cyc_q       <= cyc_d;
      timeout_q   <= timeout_d;
      target_q    <= target_d;
      tol_q       <= tol_d;
      avg_q       <= avg_d;
      avg_vld_q   <= avg_vld_d;
      in_band_q   <= in_band_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      settled_q   <= settled_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign avg_out   = avg_q;
  assign avg_vld   = avg_vld_q;
  assign in_band   = in_band_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign settled   = settled_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_settle_monitor.sv
// Directed bench for settle_monitor (NUM_CH=2, WIDTH=16, LOG_WIN=2,
// SETTLE_WINS=3). Expected window averages are pushed when a window is driven
// and popped when avg_vld is seen.
module tb_settle_monitor;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 16;
  localparam int TO_W   = 24;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic                    sample_en;
  logic [NUM_CH*WIDTH-1:0] sig;
  logic signed [WIDTH-1:0] target;
  logic [WIDTH-1:0]        tol;
  logic [TO_W-1:0]         timeout;
  logic [NUM_CH*WIDTH-1:0] avg_out;
  logic                    avg_vld;
  logic [NUM_CH-1:0]       in_band;
  logic                    busy;
  logic                    done;
  logic                    settled;
  logic                    timed_out;

  settle_monitor #(
    .NUM_CH      (NUM_CH),
    .WIDTH       (WIDTH),
    .LOG_WIN     (2),
    .SETTLE_WINS (3),
    .TIMEOUT_W   (TO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sample_en (sample_en),
    .sig       (sig),
    .target    (target),
    .tol       (tol),
    .timeout   (timeout),
    .avg_out   (avg_out),
    .avg_vld   (avg_vld),
    .in_band   (in_band),
    .busy      (busy),
    .done      (done),
    .settled   (settled),
    .timed_out (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] avg;
    logic [1:0]  ib;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start_cyc, done_cyc, done_total, done_base;
  int   vld_seen, first_vld_cyc;
  int   exp_tgt, exp_tol;
  logic signed [15:0] w0 [4];
  logic signed [15:0] w1 [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_total++;
      done_cyc = cyc;
    end
    if (avg_vld === 1'b1) begin
      if (vld_seen == 0) first_vld_cyc = cyc;
      vld_seen++;
      if (sb.size() == 0) begin
        check("avg_vld_unexpected", 32'(avg_vld), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_avg", avg_out, e.avg);
        check("sb_in_band", 32'(in_band), 32'(e.ib));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_const(input int v0, input int v1);
    for (int k = 0; k < 4; k++) begin
      w0[k] = 16'(v0);
      w1[k] = 16'(v1);
    end
  endtask

  // Start a run, then scramble the live configuration inputs: only the
  // values present on the start cycle may be used.
  task automatic do_start(input int tgt, input int tl, input int to);
    target  = 16'(tgt);
    tol     = 16'(tl);
    timeout = TO_W'(to);
    start   = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
    done_base = done_total;
    vld_seen  = 0;
    exp_tgt   = tgt;
    exp_tol   = tl;
    target    = -16'sd1234;
    tol       = 16'd0;
    timeout   = TO_W'(1);
  endtask

  // Drive one window from w0/w1 with 'gap' idle cycles before each sample,
  // then one cycle for the evaluation (optionally with a junk sample offered).
  task automatic window(input int gap, input bit poison);
    int s0, s1, a0, a1, d0, d1;
    exp_t e;
    s0 = 0;
    s1 = 0;
    for (int k = 0; k < 4; k++) begin
      s0 += int'(w0[k]);
      s1 += int'(w1[k]);
    end
    a0 = s0 >>> 2;
    a1 = s1 >>> 2;
    d0 = (a0 > exp_tgt) ? a0 - exp_tgt : exp_tgt - a0;
    d1 = (a1 > exp_tgt) ? a1 - exp_tgt : exp_tgt - a1;
    e.avg = {16'(a1), 16'(a0)};
    e.ib  = {(d1 <= exp_tol), (d0 <= exp_tol)};
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      sample_en = 1'b0;
      repeat (gap) tick();
      sig       = {w1[k], w0[k]};
      sample_en = 1'b1;
      tick();
    end
    sample_en = poison;
    sig       = {16'sd7777, 16'sd7777};
    tick();
    sample_en = 1'b0;
  endtask

  task automatic end_run(input string tag, input int exp_edge, input logic exp_set,
                         input logic exp_to);
    repeat (3) tick();
    check({tag, "_done_count"}, 32'(done_total - done_base), 32'd1);
    check({tag, "_done_edge"}, 32'(done_cyc - start_cyc), 32'(exp_edge));
    check({tag, "_settled"}, 32'(settled), 32'(exp_set));
    check({tag, "_timed_out"}, 32'(timed_out), 32'(exp_to));
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avg_out"}, avg_out, 32'd0);
    check({tag, "_avg_vld"}, 32'(avg_vld), 32'd0);
    check({tag, "_in_band"}, 32'(in_band), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_settled"}, 32'(settled), 32'd0);
    check({tag, "_timed_out"}, 32'(timed_out), 32'd0);
  endtask

  initial begin
    int base;
    done_total = 0;
    done_cyc   = 0;
    vld_seen   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    sample_en  = 1'b0;
    sig        = '0;
    target     = '0;
    tol        = '0;
    timeout    = '0;
    exp_tgt    = 0;
    exp_tol    = 0;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Constant 100 on both channels, band 150 +/- 200, continuous sampling.
    do_start(150, 200, 0);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    set_const(100, 100);
    repeat (3) window(0, 1'b1);
    check("t1_first_vld_edge", 32'(first_vld_cyc - start_cyc), 32'd5);
    end_run("t1", 15, 1'b1, 1'b0);

    // Settle and timeout on the same edge: settle wins.
    do_start(150, 200, 15);
    repeat (3) window(0, 1'b1);
    end_run("tie", 15, 1'b1, 1'b0);

    // Floor rounding of a negative average, zero tolerance.
    do_start(-3, 0, 0);
    w0 = '{-16'sd3, -16'sd2, -16'sd2, -16'sd2};
    w1 = '{-16'sd3, -16'sd3, -16'sd3, -16'sd3};
    repeat (3) window(0, 1'b1);
    end_run("floor", 15, 1'b1, 1'b0);
    check("floor_avg0", 32'(avg_out[15:0]), 32'h0000_fffd);

    // Channel 1 out of band on window 2 resets the run count.
    do_start(0, 50, 0);
    set_const(0, 0);
    window(0, 1'b1);
    set_const(0, 1000);
    window(0, 1'b1);
    set_const(0, 0);
    repeat (3) window(0, 1'b1);
    end_run("runreset", 25, 1'b1, 1'b0);

    // Never settles: 20-cycle budget expires.
    do_start(0, 50, 20);
    set_const(4000, 0);
    repeat (4) window(0, 1'b1);
    end_run("timeout", 20, 1'b0, 1'b1);
    check("timeout_in_band", 32'(in_band), 32'd2);

    // Budget 0 disables the timeout.
    do_start(0, 50, 0);
    repeat (2000) window(0, 1'b1);
    check("notimeout_done", 32'(done_total - done_base), 32'd0);
    check("notimeout_busy", 32'(busy), 32'd1);
    check("notimeout_timed_out", 32'(timed_out), 32'd0);

    // Restart mid-window: partial samples are discarded, no done from restart.
    sig       = {16'sd0, 16'sd4000};
    sample_en = 1'b1;
    repeat (2) tick();
    sample_en = 1'b0;
    do_start(0, 50, 0);
    set_const(0, 0);
    repeat (3) window(0, 1'b1);
    end_run("restart", 15, 1'b1, 1'b0);

    // Reset in the middle of a run.
    do_start(0, 50, 0);
    set_const(7, 7);
    window(0, 1'b1);
    tick();
    check("prerst_in_band", 32'(in_band), 32'd3);
    sig       = {16'sd7, 16'sd7};
    sample_en = 1'b1;
    repeat (2) tick();
    base      = done_total;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    check_reset_outputs("midrst");
    repeat (20) tick();
    sample_en = 1'b0;
    check("midrst_no_done", 32'(done_total - base), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);

    // Sparse sampling: one accepted sample every third cycle.
    do_start(150, 200, 0);
    set_const(100, 100);
    repeat (3) window(2, 1'b0);
    check("stride_first_vld_edge", 32'(first_vld_cyc - start_cyc), 32'd13);
    end_run("stride", 39, 1'b1, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
